// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle 32-bit MIPS core with req/ack instruction and data ports
//
// One shared ALU is sequenced by a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine.
// Optional feature macro: MIPS_JUMP_EN (adds the j instruction, op 0x02).
//
// Parameters: ADDR_W (PC/byte address width), NREGS (8/16/32 registers), RESET_PC (reset vector)
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/addr/ack/rdata        instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata  data access handshake
//   pc                             current program counter
//   retire                         one-cycle pulse per completed instruction
//   wb_en/wb_reg/wb_data           register-file write port observation
module mips_multicycle_core #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           NREGS    = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              wb_en,
    output logic [4:0]        wb_reg,
    output logic [31:0]       wb_data
);
    localparam int RW = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    state_e            state_q, state_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0]       regs_q [NREGS];
    logic [31:0]       regs_d [NREGS];

    logic [5:0]    opcode, funct;
    logic [31:0]   sext_imm, alu_b, alu_y;
    alu_op_e       alu_op;
    logic          is_r, r_known, is_lw, is_sw;
    logic [4:0]    dest;
    logic [RW-1:0] dest_idx;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_r     = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign r_known  = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                      (funct == 6'h25) || (funct == 6'h2A);
    assign dest     = is_r ? ir_q[15:11] : ir_q[20:16];
    assign dest_idx = dest[RW-1:0];

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_addr  = alu_q[ADDR_W-1:0];
    assign dmem_wdata = b_q;

`ifdef MIPS_JUMP_EN
    logic [31:0]       pc_ext;
    logic [ADDR_W-1:0] jump_target;
    assign pc_ext      = 32'(pc_q);
    // Upper target bits come from the already-incremented pc; bits above ADDR_W fall away.
    assign jump_target = ADDR_W'({pc_ext[31:28], ir_q[25:0], 2'b00});
`endif

    // Shared ALU: operand B is rt for R-type and beq, the sign-extended immediate otherwise.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = sext_imm;
        if (is_r) begin
            alu_b = b_q;
            case (funct)
                6'h22:   alu_op = ALU_SUB;
                6'h24:   alu_op = ALU_AND;
                6'h25:   alu_op = ALU_OR;
                6'h2A:   alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (opcode == OP_BEQ) begin
            alu_b  = b_q;
            alu_op = ALU_SUB;
        end
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = {31'd0, ($signed(a_q) < $signed(alu_b))};
            default: alu_y = a_q + alu_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        run_d    = 1'b1;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        regs_d   = regs_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        wb_en    = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = 32'd0;
        case (state_q)
            S_FETCH: begin
                // run_q keeps the request low for the first cycle after reset so a stale ack is ignored.
                imem_req = run_q;
                if (run_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // r0 is never written, so reading the array directly yields 0 for it.
                a_d     = regs_q[ir_q[21 +: RW]];
                b_d     = regs_q[ir_q[16 +: RW]];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_d = alu_y;
                if (is_lw || is_sw) begin
                    state_d = S_MEMORY;
                end else if ((is_r && r_known) || opcode == OP_ADDI) begin
                    state_d = S_WRITEBACK;
                end else begin
                    // beq, j and every unknown encoding complete here.
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (opcode == OP_BEQ && alu_y == 32'd0) begin
                        pc_d = pc_q + ADDR_W'({sext_imm[29:0], 2'b00});
                    end
`ifdef MIPS_JUMP_EN
                    if (opcode == 6'h02) begin
                        pc_d = jump_target;
                    end
`endif
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                retire  = 1'b1;
                wb_reg  = dest;
                wb_data = is_lw ? mdr_q : alu_q;
                wb_en   = (dest_idx != '0);
                if (wb_en) begin
                    regs_d[dest_idx] = wb_data;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            regs_q  <= regs_d;
        end
    end
endmodule
